icache_dm: RTL and testbench

//  Parametrised direct-mapped instruction cache between the IF stage and a word-wide backing memory.

---
 rtl/icache_dm.sv | 184 ++++++++++++++++++
 tb/tb_icache_dm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a one-outstanding-request handshake.
// A hit answers one cycle after accept. A miss fetches the whole line, one word per beat,
// and answers one cycle after the last beat. flush_i invalidates every line.
module icache_dm #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    output logic            rsp_valid_o,
    output logic [31:0]     rsp_instr_o,
    output logic            rsp_err_o,
    input  logic            flush_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [31:0]     mem_rsp_data_i,
    output logic [31:0]     miss_cnt_o
);

    localparam int unsigned OB   = $clog2(LINE_WORDS);
    localparam int unsigned IB   = $clog2(SETS);
    localparam int unsigned TLSB = OB + IB + 2;
    localparam int unsigned TW   = XLEN - TLSB;

    typedef enum logic [2:0] {StIdle, StLookup, StMemReq, StRefill, StRespond} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [OB-1:0]   cnt_q, cnt_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic            flush_seen_q, flush_seen_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    // Line store is plain flops without reset; valid_q alone qualifies its contents.
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS][LINE_WORDS];
    logic            data_we, tag_we;

    logic [OB-1:0]   word;
    logic [IB-1:0]   idx;
    logic [TW-1:0]   tag;
    logic            misaligned, hit, last_beat, accept;

    assign word       = addr_q[OB+1:2];
    assign idx        = addr_q[TLSB-1:OB+2];
    assign tag        = addr_q[XLEN-1:TLSB];
    assign misaligned = addr_q[1:0] != 2'b00;
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign last_beat  = cnt_q == OB'(LINE_WORDS - 1);
    assign accept     = req_valid_i && req_ready_o;
    assign miss_cnt_o = miss_cnt_q;

    // Output decode from the current state and the stored line contents.
    always_comb begin
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        rsp_err_o       = 1'b0;
        rsp_instr_o     = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        unique case (state_q)
            StIdle: req_ready_o = 1'b1;
            StLookup: begin
                if (misaligned) begin
                    rsp_valid_o = 1'b1;
                    rsp_err_o   = 1'b1;
                    req_ready_o = 1'b1;
                end else if (hit) begin
                    rsp_valid_o = 1'b1;
                    rsp_instr_o = data_q[idx][word];
                    req_ready_o = 1'b1;
                end
            end
            StMemReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {addr_q[XLEN-1:OB+2], {(OB + 2){1'b0}}};
            end
            StRespond: begin
                rsp_valid_o = 1'b1;
                rsp_instr_o = data_q[idx][word];
            end
            default: ;
        endcase
    end

    // Next-state logic for the controller, valid bits and refill counter.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        flush_seen_d = flush_seen_q;
        miss_cnt_d   = miss_cnt_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        if (flush_i) begin
            valid_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = req_addr_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (misaligned || hit) begin
                    if (accept) begin
                        addr_d  = req_addr_i;
                        state_d = StLookup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    flush_seen_d = 1'b0;
                    state_d      = StMemReq;
                end
            end
            StMemReq: begin
                if (flush_i) begin
                    flush_seen_d = 1'b1;
                end
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (flush_i) begin
                    flush_seen_d = 1'b1;
                end
                if (mem_rsp_valid_i) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        tag_we       = 1'b1;
                        // A flush that overlapped the refill leaves the new line invalid.
                        valid_d[idx] = !(flush_seen_q || flush_i);
                        miss_cnt_d   = miss_cnt_q + 32'd1;
                        state_d      = StRespond;
                    end
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Controller state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            cnt_q        <= '0;
            valid_q      <= '0;
            flush_seen_q <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            flush_seen_q <= flush_seen_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Line data and tag writes during refill.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx][cnt_q] <= mem_rsp_data_i;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm against a line-level behavioural cache model.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_instr_o;
    logic        rsp_err_o;
    logic        flush_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic [31:0] miss_cnt_o;

    icache_dm #(
        .XLEN       (64),
        .SETS       (16),
        .LINE_WORDS (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_instr_o     (rsp_instr_o),
        .rsp_err_o       (rsp_err_o),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .miss_cnt_o      (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model: which lines are resident, under which tag, and how many refills done.
    bit          m_valid [16];
    logic [55:0] m_tag   [16];
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Backing memory contents: a fixed program at 0x100, a hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = {a[63:2], 2'b00};
        case (w)
            64'h100: return 32'h0000_0013;
            64'h104: return 32'h0010_0093;
            64'h108: return 32'h0020_0113;
            64'h10C: return 32'h0030_0193;
            default: return (w[31:0] * 32'h9E37_79B1) ^ w[63:32] ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 32'h3FF)) & ~64'h3;
        if ($urandom_range(0, 7) == 0) a[63:32] = $urandom();
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_cnt = '0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Act as backing memory for one refill; entered at the LOOKUP negedge of a miss.
    task automatic serve_refill(input logic [63:0] a, input bit flush_mid);
        int          waited;
        int          stall;
        logic [63:0] line;
        line   = {a[63:4], 4'h0};
        waited = 0;
        while (!mem_req_valid_o && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("mem_req_valid", 64'(mem_req_valid_o), 64'd1);
        if (!mem_req_valid_o) return;
        check("mem_req_addr", mem_req_addr_o, line);
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("mem_req_hold_valid", 64'(mem_req_valid_o), 64'd1);
            check("mem_req_hold_addr", mem_req_addr_o, line);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("mem_req_drop", 64'(mem_req_valid_o), 64'd0);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("refill_gap_no_rsp", 64'(rsp_valid_o), 64'd0);
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(line + 64'(4 * b));
            if (flush_mid && b == 1) flush_i = 1'b1;
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = $urandom();
            flush_i         = 1'b0;
        end
        if (flush_mid) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end
        m_tag[a[7:4]]   = a[63:8];
        m_valid[a[7:4]] = !flush_mid;
        m_cnt           = m_cnt + 32'd1;
        check("miss_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("miss_rsp_err", 64'(rsp_err_o), 64'd0);
        check("miss_rsp_instr", 64'(rsp_instr_o), 64'(mem_word(a)));
        check("miss_cnt", 64'(miss_cnt_o), 64'(m_cnt));
    endtask

    // One fetch, classified by the model as misaligned, hit or miss.
    task automatic fetch(input logic [63:0] a, input bit flush_mid);
        int waited;
        bit mis;
        bit hit;
        waited = 0;
        @(negedge clk);
        while (!req_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_o) begin
            check("req_ready_wait", 64'(req_ready_o), 64'd1);
            return;
        end
        mis         = a[1:0] != 2'b00;
        hit         = !mis && m_valid[a[7:4]] && (m_tag[a[7:4]] == a[63:8]);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom();
        if (mis) begin
            check("mis_rsp_valid", 64'(rsp_valid_o), 64'd1);
            check("mis_rsp_err", 64'(rsp_err_o), 64'd1);
            check("mis_rsp_instr", 64'(rsp_instr_o), 64'd0);
            check("mis_no_memreq", 64'(mem_req_valid_o), 64'd0);
            @(negedge clk);
            check("mis_no_memreq_after", 64'(mem_req_valid_o), 64'd0);
        end else if (hit) begin
            check("hit_rsp_valid", 64'(rsp_valid_o), 64'd1);
            check("hit_rsp_err", 64'(rsp_err_o), 64'd0);
            check("hit_rsp_instr", 64'(rsp_instr_o), 64'(mem_word(a)));
            check("hit_no_memreq", 64'(mem_req_valid_o), 64'd0);
        end else begin
            check("miss_no_early_rsp", 64'(rsp_valid_o), 64'd0);
            serve_refill(a, flush_mid);
        end
    endtask

    // Four hits on consecutive cycles must give four consecutive responses.
    task automatic back_to_back();
        logic [63:0] a [4];
        a = '{64'h100, 64'h104, 64'h108, 64'h10C};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_rsp_valid", 64'(rsp_valid_o), 64'd1);
                check("b2b_rsp_instr", 64'(rsp_instr_o), 64'(mem_word(a[i-1])));
            end
            if (i < 4) begin
                check("b2b_ready", 64'(req_ready_o), 64'd1);
                req_valid_i = 1'b1;
                req_addr_i  = a[i];
            end else begin
                req_valid_i = 1'b0;
            end
        end
    endtask

    // Reset arrives after two refill beats; the partial line must not survive.
    task automatic reset_mid_refill();
        int waited;
        do_flush();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h100;
        @(negedge clk);
        req_valid_i = 1'b0;
        waited = 0;
        while (!mem_req_valid_o && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("rstmid_memreq", 64'(mem_req_valid_o), 64'd1);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(64'h100 + 64'(4 * b));
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("rstmid_ready", 64'(req_ready_o), 64'd1);
        check("rstmid_memreq_drop", 64'(mem_req_valid_o), 64'd0);
        check("rstmid_miss_cnt", 64'(miss_cnt_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int b = 2; b < 4; b++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(64'h100 + 64'(4 * b));
            @(negedge clk);
            check("stale_beat_no_rsp", 64'(rsp_valid_o), 64'd0);
            check("stale_beat_no_memreq", 64'(mem_req_valid_o), 64'd0);
        end
        mem_rsp_valid_i = 1'b0;
        fetch(64'h100, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b0;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(req_ready_o), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_rsp_instr", 64'(rsp_instr_o), 64'd0);
        check("reset_rsp_err", 64'(rsp_err_o), 64'd0);
        check("reset_memreq", 64'(mem_req_valid_o), 64'd0);
        check("reset_memreq_addr", mem_req_addr_o, 64'd0);
        check("reset_miss_cnt", 64'(miss_cnt_o), 64'd0);
        rst = 1'b1;

        fetch(64'h100, 1'b0);
        fetch(64'h108, 1'b0);
        back_to_back();
        fetch(64'h1100, 1'b0);
        fetch(64'h100, 1'b0);
        check("conflict_miss_cnt", 64'(miss_cnt_o), 64'd3);
        do_flush();
        fetch(64'h104, 1'b0);
        fetch(64'h108, 1'b1);
        fetch(64'h108, 1'b0);
        fetch(64'h102, 1'b0);
        reset_mid_refill();

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            else fetch(rand_addr(), $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
